cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_arbiter_result_fifo.sv | 78 +++++++
 rtl/cdb_arbiter.sv | 120 ++++++++++++
 tb/tb_cdb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Constants shared by the RS, LSB, ROB and CDB arbiter: widths, the tag-0
// "no dependency" encoding, result-producer indices and the round-robin helper.
package cdb_arbiter_pkg;

   localparam int CDB_TAG_W  = 4;
   localparam int CDB_DATA_W = 32;
   localparam int IDX_W      = 2;
   localparam int TAG_NONE   = 0;

   typedef enum logic [IDX_W-1:0] {
      SRC_ALU = 2'd0,
      SRC_LSB = 2'd1,
      SRC_BRU = 2'd2
   } src_id_e;

   localparam int NUM_SRC_DEF = int'(SRC_BRU) + 1;

   // Source visited at step 'offset' of a round-robin scan that starts at 'base'.
   function automatic int rr_index(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result holding buffer: DEPTH entries, push/pop/flush, occupancy count.
// A push into a full FIFO is dropped here; the caller never offers one.
module result_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 36,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic [CNT_W-1:0] count,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_push = push && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop && (count_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the cleared count and pointers
   // already mark every slot invalid, and a resettable RAM costs routing.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from NUM_SRC producers and broadcasts
// at most one per cycle, chosen round-robin, on a registered CDB.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int TAG_W   = CDB_TAG_W,
   parameter int DATA_W  = CDB_DATA_W,
   parameter int DEPTH   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_W-1:0] src_value,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_value,
   output logic [IDX_W-1:0]          cdb_src
);
   localparam int ENTRY_W = TAG_W + DATA_W;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic [NUM_SRC-1:0] fifo_push, fifo_pop, fifo_empty;
   logic [ENTRY_W-1:0] fifo_head  [NUM_SRC];
   logic [CNT_W-1:0]   fifo_count [NUM_SRC];

   logic               grant_any;
   int                 grant_k;
   logic [ENTRY_W-1:0] grant_entry;

   logic               cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
   logic [IDX_W-1:0]   cdb_src_q, cdb_src_d;
   logic [IDX_W-1:0]   rr_q, rr_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [TAG_W-1:0] tag_i;
      assign tag_i = src_tag[i*TAG_W +: TAG_W];

      // Ready looks only at occupancy, so a full FIFO refuses even while it drains.
      assign src_ready[i] = (fifo_count[i] < CNT_W'(DEPTH)) && rdy && !flush;
      assign fifo_push[i] = src_valid[i] && src_ready[i] && (tag_i != TAG_W'(TAG_NONE));

      result_fifo #(
         .DEPTH (DEPTH),
         .W     (ENTRY_W)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (fifo_push[i]),
         .pop   (fifo_pop[i]),
         .din   ({tag_i, src_value[i*DATA_W +: DATA_W]}),
         .dout  (fifo_head[i]),
         .count (fifo_count[i]),
         .empty (fifo_empty[i])
      );
   end

   // NOTE: every signal gets a default before any branch, so no path leaves a
   // combinational output unassigned and no latch can be inferred.
   always_comb begin
      grant_any = 1'b0;
      grant_k   = 0;
      fifo_pop  = '0;
      if (rdy && !flush) begin
         for (int j = 0; j < NUM_SRC; j++) begin
            if (!grant_any && !fifo_empty[rr_index(int'(rr_q), j, NUM_SRC)]) begin
               grant_any = 1'b1;
               grant_k   = rr_index(int'(rr_q), j, NUM_SRC);
            end
         end
      end
      if (grant_any) fifo_pop[grant_k] = 1'b1;
      grant_entry = fifo_head[grant_k];
   end

   always_comb begin
      cdb_valid_d = grant_any;
      cdb_tag_d   = cdb_tag_q;
      cdb_value_d = cdb_value_q;
      cdb_src_d   = cdb_src_q;
      rr_d        = rr_q;
      if (grant_any) begin
         cdb_tag_d   = grant_entry[ENTRY_W-1 -: TAG_W];
         cdb_value_d = grant_entry[DATA_W-1:0];
         cdb_src_d   = IDX_W'(grant_k);
         rr_d        = IDX_W'(rr_index(grant_k, 1, NUM_SRC));
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
         cdb_src_q   <= '0;
         rr_q        <= '0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_value_q <= cdb_value_d;
         cdb_src_q   <= cdb_src_d;
         rr_q        <= rr_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_value = cdb_value_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts every
// broadcast; a negedge monitor compares whatever the CDB presents.
module tb_cdb_arbiter;
   localparam int NS    = 3;
   localparam int TW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic             clk;
   logic             rst, rdy, flush;
   logic [NS-1:0]    src_valid;
   logic [NS*TW-1:0] src_tag;
   logic [NS*DW-1:0] src_value;
   logic [NS-1:0]    src_ready;
   logic             cdb_valid;
   logic [TW-1:0]    cdb_tag;
   logic [DW-1:0]    cdb_value;
   logic [1:0]       cdb_src;

   cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (flush),
      .src_valid (src_valid),
      .src_tag   (src_tag),
      .src_value (src_value),
      .src_ready (src_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] value;
   } ent_t;

   typedef struct {
      int            due;
      logic [TW-1:0] tag;
      logic [DW-1:0] value;
      int            src;
   } exp_t;

   ent_t          mq [NS][$];
   exp_t          exp_q [$];
   int            rr_m = 0;
   int            cyc = 0;
   logic [TW-1:0] hold_tag = '0;
   logic [DW-1:0] hold_value = '0;
   int            hold_src = 0;

   int            obs_src [$];
   logic [TW-1:0] obs_tag [$];
   logic [DW-1:0] obs_val [$];

   int            n_checks = 0;
   int            n_pass = 0;
   logic [NS-1:0] ready_s;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // Reference model: per-source queues, round-robin pointer, one pop per edge.
   always @(posedge clk) begin : model
      logic [NS-1:0] acc;
      int            granted;
      ent_t          e;
      cyc++;
      if (rst) begin
         for (int i = 0; i < NS; i++) mq[i].delete();
         exp_q.delete();
         rr_m = 0;
         hold_tag = '0;
         hold_value = '0;
         hold_src = 0;
      end else if (flush) begin
         for (int i = 0; i < NS; i++) mq[i].delete();
      end else if (rdy) begin
         for (int i = 0; i < NS; i++) acc[i] = src_valid[i] && (mq[i].size() < DEPTH);
         granted = -1;
         for (int j = 0; j < NS; j++)
            if (granted < 0 && mq[(rr_m + j) % NS].size() > 0) granted = (rr_m + j) % NS;
         if (granted >= 0) begin
            e = mq[granted].pop_front();
            exp_q.push_back('{cyc, e.tag, e.value, granted});
            hold_tag = e.tag;
            hold_value = e.value;
            hold_src = granted;
            rr_m = (granted + 1) % NS;
         end
         for (int i = 0; i < NS; i++)
            if (acc[i] && src_tag[i*TW +: TW] != '0)
               mq[i].push_back('{src_tag[i*TW +: TW], src_value[i*DW +: DW]});
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      for (int i = 0; i < NS; i++)
         check($sformatf("src_ready[%0d]", i), 64'(src_ready[i]),
               64'((mq[i].size() < DEPTH) && rdy && !flush));
      if (cdb_valid === 1'b1) begin
         obs_src.push_back(int'(cdb_src));
         obs_tag.push_back(cdb_tag);
         obs_val.push_back(cdb_value);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check("cdb_valid_bcast", 64'(cdb_valid), 64'(1));
         check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
         check("cdb_value", 64'(cdb_value), 64'(e.value));
         check("cdb_src", 64'(cdb_src), 64'(e.src));
      end else begin
         check("cdb_valid_idle", 64'(cdb_valid), 64'(0));
         check("cdb_tag_hold", 64'(cdb_tag), 64'(hold_tag));
         check("cdb_value_hold", 64'(cdb_value), 64'(hold_value));
         check("cdb_src_hold", 64'(cdb_src), 64'(hold_src));
      end
   end

   task automatic step();
      @(negedge clk);
      ready_s = src_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
      src_valid[i] = v;
      src_tag[i*TW +: TW] = t;
      src_value[i*DW +: DW] = d;
   endtask

   task automatic idle();
      src_valid = '0;
      src_tag = '0;
      src_value = '0;
   endtask

   task automatic clear_obs();
      obs_src.delete();
      obs_tag.delete();
      obs_val.delete();
   endtask

   task automatic reset_and_check();
      rst = 1'b1;
      flush = 1'b0;
      rdy = 1'b1;
      idle();
      @(posedge clk);
      @(negedge clk);
      check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
      check("rst_cdb_tag", 64'(cdb_tag), 64'(0));
      check("rst_cdb_value", 64'(cdb_value), 64'(0));
      check("rst_cdb_src", 64'(cdb_src), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin : stim
      int bp_tags [3];
      int idx1;
      logic bp_seen;
      int n1;
      bp_tags = '{4, 5, 6};
      rst = 1'b1;
      rdy = 1'b1;
      flush = 1'b0;
      idle();
      reset_and_check();

      // Single push: broadcast one edge after the push edge, exactly once.
      clear_obs();
      set_src(0, 1'b1, 4'd3, 32'h0000_00AA);
      step();
      idle();
      repeat (4) step();
      check("single_count", 64'(obs_src.size()), 64'(1));
      if (obs_src.size() == 1) begin
         check("single_tag", 64'(obs_tag[0]), 64'(3));
         check("single_value", 64'(obs_val[0]), 64'h0000_00AA);
         check("single_src", 64'(obs_src[0]), 64'(0));
      end

      // Contention from rr=0: order src0, src1, src2.
      reset_and_check();
      clear_obs();
      for (int i = 0; i < NS; i++) set_src(i, 1'b1, TW'(i + 1), DW'(32'h100 + i));
      step();
      idle();
      repeat (5) step();
      check("contend_count", 64'(obs_src.size()), 64'(3));
      for (int i = 0; i < 3 && i < obs_src.size(); i++) begin
         check($sformatf("contend_src%0d", i), 64'(obs_src[i]), 64'(i));
         check($sformatf("contend_tag%0d", i), 64'(obs_tag[i]), 64'(i + 1));
      end
      // rr should be back at 0: src0 beats src1 when both push now.
      clear_obs();
      set_src(0, 1'b1, 4'd9, 32'h9);
      set_src(1, 1'b1, 4'd10, 32'hA);
      step();
      idle();
      repeat (4) step();
      if (obs_src.size() > 0) check("rr_wrap_first", 64'(obs_src[0]), 64'(0));
      else check("rr_wrap_first_present", 64'(obs_src.size()), 64'(2));

      // Backpressure: src0/src2 keep pushing; src1 holds tags 4,5,6 until accepted.
      reset_and_check();
      clear_obs();
      idx1 = 0;
      bp_seen = 1'b0;
      for (int c = 0; c < 40 && idx1 < 3; c++) begin
         set_src(0, 1'b1, TW'($urandom_range(1, 15)), $urandom);
         set_src(2, 1'b1, TW'($urandom_range(1, 15)), $urandom);
         set_src(1, 1'b1, TW'(bp_tags[idx1]), DW'(32'h4000 + idx1));
         step();
         if (!ready_s[1]) bp_seen = 1'b1;
         if (ready_s[1]) idx1++;
      end
      check("bp_all_accepted", 64'(idx1), 64'(3));
      check("bp_ready_low_seen", 64'(bp_seen), 64'(1));
      idle();
      repeat (10) step();
      n1 = 0;
      for (int i = 0; i < obs_src.size(); i++) begin
         if (obs_src[i] == 1) begin
            if (n1 < 3) check($sformatf("bp_order%0d", n1), 64'(obs_tag[i]), 64'(bp_tags[n1]));
            n1++;
         end
      end
      check("bp_src1_count", 64'(n1), 64'(3));

      // Flush with entries pending everywhere.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NS; i++) set_src(i, 1'b1, TW'($urandom_range(1, 15)), $urandom);
         step();
      end
      idle();
      flush = 1'b1;
      step();
      flush = 1'b0;
      clear_obs();
      repeat (6) step();
      check("flush_no_bcast", 64'(obs_src.size()), 64'(0));

      // Freeze: pending entry waits out three rdy=0 edges, then goes once.
      set_src(2, 1'b1, 4'd7, 32'h7777);
      step();
      idle();
      clear_obs();
      rdy = 1'b0;
      repeat (3) step();
      check("freeze_silent", 64'(obs_src.size()), 64'(0));
      rdy = 1'b1;
      repeat (4) step();
      check("freeze_once", 64'(obs_src.size()), 64'(1));
      if (obs_src.size() > 0) check("freeze_tag", 64'(obs_tag[0]), 64'(7));

      // Tag 0 is accepted but never broadcast.
      clear_obs();
      set_src(1, 1'b1, 4'd0, 32'h55);
      step();
      idle();
      repeat (3) step();
      check("tag0_no_bcast", 64'(obs_src.size()), 64'(0));

      // Reset mid-operation discards pending work.
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < NS; i++) set_src(i, 1'b1, TW'($urandom_range(1, 15)), $urandom);
         step();
      end
      reset_and_check();
      clear_obs();
      repeat (5) step();
      check("rst_no_bcast", 64'(obs_src.size()), 64'(0));

      // Random traffic with occasional freeze, flush and reset.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NS; i++)
            set_src(i, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)), $urandom);
         rdy = ($urandom_range(0, 99) < 85);
         flush = ($urandom_range(0, 99) < 3);
         rst = ($urandom_range(0, 199) < 1);
         step();
      end
      rst = 1'b0;
      flush = 1'b0;
      rdy = 1'b1;
      idle();
      repeat (10) step();
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
